// File: rtl/uart_pkg.sv
// Shared UART types and constants.
// Receiver FSM states, legal prescale ratios, default frame width.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   localparam logic [5:0] PRESCALE_8  = 6'd8;
   localparam logic [5:0] PRESCALE_16 = 6'd16;
   localparam logic [5:0] PRESCALE_32 = 6'd32;

   localparam int DEFAULT_DATA_WIDTH = 8;

   // Unsupported ratios fall back to 8x.
   function automatic logic [5:0] eff_prescale(input logic [5:0] p);
      case (p)
         PRESCALE_16: return PRESCALE_16;
         PRESCALE_32: return PRESCALE_32;
         default:     return PRESCALE_8;
      endcase
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counter with three-sample majority vote.
// Samples around mid-bit, resolves two cycles after the centre.
module uart_rx_sampler
   import uart_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       rx_in,
   input  logic [5:0] prescale,
   output logic       sampled_bit,
   output logic       sample_done,
   output logic       bit_end
);

   logic [5:0] p;
   logic [5:0] half;
   logic [5:0] edge_cnt;
   logic [2:0] smp;

   assign p    = eff_prescale(prescale);
   assign half = p >> 1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_cnt <= '0;
         smp      <= '0;
      end else begin
         if (!en)
            edge_cnt <= '0;
         else if (edge_cnt == p - 6'd1)
            edge_cnt <= '0;
         else
            edge_cnt <= edge_cnt + 6'd1;

         if (en) begin
            if (edge_cnt == half - 6'd1) smp[0] <= rx_in;
            if (edge_cnt == half)        smp[1] <= rx_in;
            if (edge_cnt == half + 6'd1) smp[2] <= rx_in;
         end
      end
   end

   assign sampled_bit = (smp[0] & smp[1]) |
                        (smp[0] & smp[2]) |
                        (smp[1] & smp[2]);
   assign sample_done = en && (edge_cnt == half + 6'd2);
   assign bit_end     = en && (edge_cnt == p - 6'd1);

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start/data/parity/stop deserializer.
// Stop bit resolves half a bit early so back-to-back frames are caught.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [5:0]            prescale,
   input  logic                  par_en,
   input  logic                  par_typ,
   output logic [DATA_WIDTH-1:0] p_data,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err,
   output logic                  busy
);

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);

   rx_state_t             state;
   logic [BW-1:0]         bit_cnt;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic                  par_en_q;
   logic                  par_typ_q;
   logic                  par_fail;
   logic                  sampled_bit;
   logic                  sample_done;
   logic                  bit_end;
   logic                  active;

   assign active = (state != IDLE);

   uart_rx_sampler u_sampler (
      .clk         (CLK),
      .rst_n       (RST),
      .en          (active),
      .rx_in       (RX_IN),
      .prescale    (prescale),
      .sampled_bit (sampled_bit),
      .sample_done (sample_done),
      .bit_end     (bit_end)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         par_fail   <= 1'b0;
         p_data     <= '0;
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
         case (state)
            IDLE: begin
               if (!RX_IN) begin
                  state     <= START;
                  busy      <= 1'b1;
                  par_en_q  <= par_en;
                  par_typ_q <= par_typ;
                  par_fail  <= 1'b0;
                  bit_cnt   <= '0;
               end
            end
            START: begin
               if (sample_done && sampled_bit) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (bit_end) begin
                  state <= DATA;
               end
            end
            DATA: begin
               if (sample_done)
                  shift_reg[bit_cnt] <= sampled_bit;
               if (bit_end) begin
                  if (bit_cnt == LAST) begin
                     bit_cnt <= '0;
                     state   <= par_en_q ? PARITY : STOP;
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                  end
               end
            end
            PARITY: begin
               if (sample_done)
                  par_fail <= sampled_bit ^ (^shift_reg) ^ par_typ_q;
               if (bit_end)
                  state <= STOP;
            end
            STOP: begin
               if (sample_done) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (!sampled_bit) begin
                     stp_err <= 1'b1;
                  end else if (par_fail) begin
                     par_err <= 1'b1;
                  end else begin
                     p_data     <= shift_reg;
                     data_valid <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames, errors, glitch,
// back-to-back traffic and mid-frame reset.
module tb_uart_rx;

   typedef struct packed {
      logic [2:0]  kind;
      logic [7:0]  data;
      logic [31:0] cyc;
   } ev_t;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       RX_IN = 1'b1;
   logic [5:0] prescale = 6'd8;
   logic       par_en = 1'b0;
   logic       par_typ = 1'b0;
   logic [7:0] p_data;
   logic       data_valid;
   logic       par_err;
   logic       stp_err;
   logic       busy;

   int   cyc = 0;
   int   busy_cnt = 0;
   int   errors = 0;
   int   checks = 0;
   logic [7:0] last_good = 8'h00;
   ev_t  exp_q[$];
   ev_t  obs_q[$];

   uart_rx #(.DATA_WIDTH(8)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .RX_IN      (RX_IN),
      .prescale   (prescale),
      .par_en     (par_en),
      .par_typ    (par_typ),
      .p_data     (p_data),
      .data_valid (data_valid),
      .par_err    (par_err),
      .stp_err    (stp_err),
      .busy       (busy)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (data_valid || par_err || stp_err)
         obs_q.push_back(ev_t'{kind: {data_valid, par_err, stp_err},
                               data: p_data, cyc: 32'(cyc)});
      if (busy) busy_cnt++;
   end

   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic drive_bit(input logic b, input int n);
      RX_IN = b;
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // kind: {valid, par_err, stp_err}
   task automatic send_frame(input logic [7:0] d, input logic pen,
                             input logic ptyp, input logic pbit,
                             input logic stop);
      int p;
      int n;
      ev_t e;
      p = int'(prescale);
      n = 1 + 8 + (pen ? 1 : 0);
      if (!stop) begin
         e.kind = 3'b001;
      end else if (pen && (pbit != ((^d) ^ ptyp))) begin
         e.kind = 3'b010;
      end else begin
         e.kind = 3'b100;
         last_good = d;
      end
      e.data = last_good;
      e.cyc = 32'(cyc + n * p + p / 2 + 4);
      exp_q.push_back(e);
      par_en = pen;
      par_typ = ptyp;
      drive_bit(1'b0, p);
      for (int i = 0; i < 8; i++) drive_bit(d[i], p);
      if (pen) drive_bit(pbit, p);
      if (stop) begin
         drive_bit(1'b1, p);
      end else begin
         drive_bit(1'b0, p / 2 + 3);
         RX_IN = 1'b1;
      end
   endtask

   task automatic wait_events(input int n, output bit ok);
      for (int i = 0; i < 3000 && obs_q.size() < n; i++)
         @(posedge CLK);
      ok = (obs_q.size() >= n);
   endtask

   task automatic test_reset;
      RST = 1'b0;
      idle(3);
      checks++;
      if (p_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_p_data got=%h want=00", p_data);
      end
      checks++;
      if (data_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid got=%b want=0", data_valid);
      end
      checks++;
      if (par_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_par_err got=%b want=0", par_err);
      end
      checks++;
      if (stp_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_stp_err got=%b want=0", stp_err);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy got=%b want=0", busy);
      end
      @(negedge CLK);
      RST = 1'b1;
      idle(3);
   endtask

   task automatic test_good_frame;
      bit ok;
      ev_t e;
      ev_t o;
      prescale = 6'd8;
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
      wait_events(1, ok);
      idle(20);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL good_timeout got=0 events want=1");
         exp_q.delete();
      end else begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL good_event got=%b/%h@%0d want=%b/%h@%0d",
                     o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL good_extra got=%0d want=0", obs_q.size());
         obs_q.delete();
      end
      checks++;
      if (p_data !== 8'hA5) begin
         errors++;
         $display("FAIL good_p_data got=%h want=a5", p_data);
      end
   endtask

   task automatic test_parity_error;
      bit ok;
      ev_t e;
      ev_t o;
      prescale = 6'd16;
      send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1);
      wait_events(1, ok);
      idle(20);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL par_timeout got=0 events want=1");
         exp_q.delete();
      end else begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL par_event got=%b/%h@%0d want=%b/%h@%0d",
                     o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL par_extra got=%0d want=0", obs_q.size());
         obs_q.delete();
      end
      checks++;
      if (p_data !== last_good) begin
         errors++;
         $display("FAIL par_p_data got=%h want=%h", p_data, last_good);
      end
   endtask

   task automatic test_stop_error;
      bit ok;
      ev_t e;
      ev_t o;
      prescale = 6'd32;
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
      wait_events(1, ok);
      idle(40);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL stp_timeout got=0 events want=1");
         exp_q.delete();
      end else begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL stp_event got=%b/%h@%0d want=%b/%h@%0d",
                     o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL stp_extra got=%0d want=0", obs_q.size());
         obs_q.delete();
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL stp_idle busy got=%b want=0", busy);
      end
   endtask

   task automatic test_glitch;
      int b0;
      prescale = 6'd8;
      b0 = busy_cnt;
      drive_bit(1'b0, 2);
      drive_bit(1'b1, 30);
      checks++;
      if (busy_cnt - b0 != 7) begin
         errors++;
         $display("FAIL glitch_busy_len got=%0d want=7", busy_cnt - b0);
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL glitch_strobe got=%0d want=0", obs_q.size());
         obs_q.delete();
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL glitch_busy got=%b want=0", busy);
      end
   endtask

   task automatic test_back_to_back;
      bit ok;
      ev_t e;
      ev_t o;
      prescale = 6'd16;
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
      send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
      wait_events(2, ok);
      idle(30);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL b2b_timeout got=%0d events want=2", obs_q.size());
         exp_q.delete();
         obs_q.delete();
      end else begin
         for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
               errors++;
               $display("FAIL b2b_event%0d got=%b/%h@%0d want=%b/%h@%0d",
                        i, o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_extra got=%0d want=0", obs_q.size());
         obs_q.delete();
      end
      checks++;
      if (p_data !== 8'hC3) begin
         errors++;
         $display("FAIL b2b_p_data got=%h want=c3", p_data);
      end
   endtask

   task automatic test_reset_mid;
      bit ok;
      ev_t e;
      ev_t o;
      logic [7:0] d;
      d = 8'h5A;
      prescale = 6'd8;
      par_en = 1'b0;
      drive_bit(1'b0, 8);
      for (int i = 0; i < 3; i++) drive_bit(d[i], 8);
      RX_IN = d[3];
      repeat (4) @(posedge CLK);
      #2 RST = 1'b0;
      #1;
      checks++;
      if ({p_data, data_valid, par_err, stp_err, busy} !== 12'h000) begin
         errors++;
         $display("FAIL rst_mid_outs got=%h/%b%b%b%b want=00/0000",
                  p_data, data_valid, par_err, stp_err, busy);
      end
      RX_IN = 1'b1;
      last_good = 8'h00;
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      idle(5);
      send_frame(d, 1'b0, 1'b0, 1'b0, 1'b1);
      wait_events(1, ok);
      idle(20);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rst_mid_timeout got=0 events want=1");
         exp_q.delete();
      end else begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL rst_mid_event got=%b/%h@%0d want=%b/%h@%0d",
                     o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL rst_mid_extra got=%0d want=0", obs_q.size());
         obs_q.delete();
      end
      checks++;
      if (p_data !== 8'h5A) begin
         errors++;
         $display("FAIL rst_mid_p_data got=%h want=5a", p_data);
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_parity_error();
      test_stop_error();
      test_glitch();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver; the receive-side counterpart of the system's UART transmitter. Deserializes a start/data/optional-parity/stop frame from the RX line, checks parity and stop bit, and presents the byte to the system controller with a one-cycle valid strobe. Runs in the UART clock domain, whose frequency is `prescale` times the bit rate.

## Interface
Parameters:
- `DATA_WIDTH`, 8, number of data bits per frame, sent LSB first.

Ports:
- `CLK`, input, 1, UART oversampling clock. One clock.
- `RST`, input, 1, asynchronous, active-low reset.
- `RX_IN`, input, 1, serial line; idles high. Already synchronous to `CLK`; the upstream synchronizer owns this.
- `prescale`, input, 6, oversampling ratio. 8, 16 and 32 are legal; any other value is treated as 8. Changed only while `busy` = 0.
- `par_en`, input, 1, 1 = a parity bit follows the data.
- `par_typ`, input, 1, 0 = even parity, 1 = odd parity.
- `p_data`, output, `DATA_WIDTH`, last correctly received byte.
- `data_valid`, output, 1, one-cycle strobe when `p_data` updates.
- `par_err`, output, 1, one-cycle strobe on a parity mismatch.
- `stp_err`, output, 1, one-cycle strobe when the stop bit is sampled as 0.
- `busy`, output, 1, high from start detection until the frame ends.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Counters:
  - `edge_cnt` counts 0..P-1 within each bit, where P is the effective prescale.
  - `bit_cnt` counts 0..DATA_WIDTH-1 in DATA.
- Sampling:
  - Samples are taken at `edge_cnt` = P/2-1, P/2 and P/2+1.
  - The bit value is the 2-of-3 majority, resolved at `edge_cnt` = P/2+2.
- IDLE: when `RX_IN` = 0 in a cycle, go to START and set `edge_cnt` = 0 in the next cycle.
- START:
  - Resolved value 1 = glitch: return to IDLE. No outputs; no error flags.
  - Resolved value 0: at `edge_cnt` = P-1, go to DATA.
- DATA:
  - Shift the resolved bit into the shift register at bit position `bit_cnt`.
  - After bit DATA_WIDTH-1 completes, go to PARITY if `par_en` = 1, else STOP.
- PARITY: expected bit = XOR of the data bits, then XOR `par_typ`. A mismatch sets the internal parity-fail flag.
- STOP:
  - At resolution, go directly to IDLE. This is half a bit early and absorbs clock drift, so a following start edge can be detected.
  - In the next cycle, exactly one of these applies:
    - stop bit = 0: `stp_err` = 1.
    - else if parity failed: `par_err` = 1.
    - else: `p_data` is loaded and `data_valid` = 1.
- `p_data` holds its value until the next good frame. An errored frame never changes `p_data`.
- `par_en` and `par_typ` are sampled at start detection and held for the whole frame.

## Timing
- Reset value of every output is 0, `p_data` included. The FSM resets to IDLE and all counters clear.
- Reset asserted mid-frame aborts the frame immediately, with no strobes.
- Latency: `data_valid` asserts exactly 1 cycle after the stop bit's resolution cycle. Counted from the first start-bit low sample, that is N×P + P/2 + 4 cycles, where N = 1 + DATA_WIDTH + `par_en`.
- All strobes last exactly 1 cycle. `data_valid`, `par_err` and `stp_err` are mutually exclusive.
- `busy` rises in the cycle after the start edge is seen and falls when the FSM returns to IDLE.
- Back-to-back frames: a start edge in the cycle right after the STOP resolution is accepted. That cycle's strobe and the new frame's START run concurrently.
- Minimum frame spacing: the stop bit only.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (IDLE/START/DATA/PARITY/STOP);
  - prescale constants 8/16/32;
  - the default data width.
- One sub-module, `uart_rx_sampler`. It contains the `edge_cnt` counter, the three-sample capture and the majority vote, and outputs `sampled_bit`, `sample_done` and `bit_end`.
- The top level contains the FSM, `bit_cnt`, the shift register, the parity check and the output registers.

## Test plan
- Prescale 8, parity on, even, send 0xA5 with parity bit 0 and stop 1: `data_valid` pulses once, `p_data` = 0xA5, no errors.
- Prescale 16, parity on, odd, send 0xA5 with parity bit 0: `par_err` pulses once, `p_data` keeps its previous value, `data_valid` stays 0.
- Prescale 32, parity off, send 0x3C with stop bit 0: `stp_err` pulses once and the FSM returns to IDLE.
- Prescale 8, drive `RX_IN` low for 2 cycles then high: no strobes, and `busy` falls when the START bit resolves.
- Prescale 16, parity off, send 0x3C then 0xC3 with only one stop bit between them: two `data_valid` pulses carrying 0x3C then 0xC3.
- Assert `RST` during DATA bit 3: all outputs are 0 immediately; after release, a clean 0x5A frame is received correctly.
